// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI requester arbiter.
//   arb_state_e      : arbiter FSM states
//   QSPI_ADDR_W      : flash address bits that are compared and used by flash
//   QSPI_RD_LATENCY  : approximate flash read latency in cycles after m_psel rises
//   QSPI_MAX_REQ     : maximum number of requester ports
//   QSPI_IDX_W       : width of a requester index
package qspi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HIT  = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int unsigned QSPI_ADDR_W     = 24;
  localparam int unsigned QSPI_RD_LATENCY = 29;
  localparam int unsigned QSPI_MAX_REQ    = 4;
  localparam int unsigned QSPI_IDX_W      = $clog2(QSPI_MAX_REQ);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector (one bit per requester)
//   ptr   : index with highest priority this round
//   valid : some request bit is set
//   idx   : first set request at or after ptr, wrapping modulo N_REQ
module rr_pick
  import qspi_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [QSPI_IDX_W-1:0] ptr,
  output logic                  valid,
  output logic [QSPI_IDX_W-1:0] idx
);

  logic [QSPI_IDX_W:0] cand;

  // Walk from ptr upward; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (QSPI_IDX_W+1)'(ptr) + (QSPI_IDX_W+1)'(i);
      if (cand >= (QSPI_IDX_W+1)'(N_REQ)) begin
        cand = cand - (QSPI_IDX_W+1)'(N_REQ);
      end
      if (!valid && 1'(req >> cand)) begin
        valid = 1'b1;
        idx   = cand[QSPI_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/qspi_arbiter.sv
// Round-robin arbiter sharing one qspi_controller slave port between N_REQ
// requesters, with an optional one-entry last-read buffer.
//   s_pclk, s_preset        : clock, synchronous active-high reset
//   r_psel/r_pwrite/r_paddr : per-requester request (addr packed 32 bits each)
//   r_pready/r_prdata       : one-hot completion pulse and read data
//   flush                   : invalidates the last-read buffer
//   m_psel/m_pwrite/m_paddr : registered request towards the controller
//   m_pready/m_prdata       : completion and read data from the controller
module qspi_arbiter
  import qspi_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter bit          HIT_EN = 1'b1
) (
  input  logic                s_pclk,
  input  logic                s_preset,
  input  logic [N_REQ-1:0]    r_psel,
  input  logic [N_REQ-1:0]    r_pwrite,
  input  logic [N_REQ*32-1:0] r_paddr,
  output logic [N_REQ-1:0]    r_pready,
  output logic [31:0]         r_prdata,
  input  logic                flush,
  output logic                m_psel,
  output logic                m_pwrite,
  output logic [31:0]         m_paddr,
  input  logic                m_pready,
  input  logic [31:0]         m_prdata
);

  arb_state_e             state_q, state_d;
  logic [QSPI_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [QSPI_IDX_W-1:0]  grant_q, grant_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [QSPI_ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]            buf_data_q, buf_data_d;
  logic                   m_psel_q, m_psel_d;
  logic                   m_pwrite_q, m_pwrite_d;
  logic [31:0]            m_paddr_q, m_paddr_d;

  logic                   pick_valid;
  logic [QSPI_IDX_W-1:0]  pick_idx;
  logic                   pick_wr;
  logic [31:0]            pick_paddr;
  logic                   pick_hit;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (r_psel),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Fields of the candidate request and its buffer lookup.
  always_comb begin
    pick_wr    = 1'(r_pwrite >> pick_idx);
    pick_paddr = 32'(r_paddr >> {pick_idx, 5'd0});
    pick_hit   = HIT_EN && !pick_wr && buf_valid_q &&
                 (pick_paddr[QSPI_ADDR_W-1:0] == buf_addr_q);
  end

  // Next-state and buffer update.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    m_psel_d    = m_psel_q;
    m_pwrite_d  = m_pwrite_q;
    m_paddr_d   = m_paddr_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          if (pick_hit) begin
            state_d = HIT;
          end else begin
            state_d    = BUSY;
            m_psel_d   = 1'b1;
            m_pwrite_d = pick_wr;
            m_paddr_d  = pick_paddr;
          end
        end
      end
      BUSY: begin
        if (m_pready) begin
          state_d  = GAP;
          m_psel_d = 1'b0;
          if (m_pwrite_q) begin
            buf_valid_d = 1'b0;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = m_paddr_q[QSPI_ADDR_W-1:0];
            buf_data_d  = m_prdata;
          end
        end
      end
      HIT: begin
        state_d = GAP;
      end
      GAP: begin
        state_d  = IDLE;
        rr_ptr_d = (grant_q == QSPI_IDX_W'(N_REQ - 1)) ? '0 : grant_q + QSPI_IDX_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over a same-cycle read capture.
    if (flush) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge s_pclk) begin
    if (s_preset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      m_psel_q    <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      m_psel_q    <= m_psel_d;
      m_pwrite_q  <= m_pwrite_d;
      m_paddr_q   <= m_paddr_d;
    end
  end

  // Completion is a pass-through of the controller in BUSY, local in HIT.
  always_comb begin
    r_pready = '0;
    r_prdata = '0;
    if (state_q == BUSY) begin
      r_pready = N_REQ'(m_pready) << grant_q;
      r_prdata = m_prdata;
    end else if (state_q == HIT) begin
      r_pready = N_REQ'(1) << grant_q;
      r_prdata = buf_data_q;
    end
  end

  assign m_psel   = m_psel_q;
  assign m_pwrite = m_pwrite_q;
  assign m_paddr  = m_paddr_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Directed bench for qspi_arbiter with a cycle-level qspi_controller model.
module tb_qspi_arbiter;

  localparam int N = 2;

  logic            s_pclk = 1'b0;
  logic            s_preset;
  logic [N-1:0]    r_psel;
  logic [N-1:0]    r_pwrite;
  logic [N*32-1:0] r_paddr;
  logic [N-1:0]    r_pready;
  logic [31:0]     r_prdata;
  logic            flush;
  logic            m_psel;
  logic            m_pwrite;
  logic [31:0]     m_paddr;
  logic            m_pready;
  logic [31:0]     m_prdata;

  int errors = 0;
  int checks = 0;

  qspi_arbiter #(.N_REQ(N), .HIT_EN(1'b1)) dut (
    .s_pclk   (s_pclk),
    .s_preset (s_preset),
    .r_psel   (r_psel),
    .r_pwrite (r_pwrite),
    .r_paddr  (r_paddr),
    .r_pready (r_pready),
    .r_prdata (r_prdata),
    .flush    (flush),
    .m_psel   (m_psel),
    .m_pwrite (m_pwrite),
    .m_paddr  (m_paddr),
    .m_pready (m_pready),
    .m_prdata (m_prdata)
  );

  always #5 s_pclk = ~s_pclk;

  function automatic logic [31:0] flash_fn(input logic [31:0] a);
    if (a[23:0] == 24'h123456) return 32'hCAFE_BABE;
    return {8'hA5, a[23:0]};
  endfunction

  // Controller model: m_pready 2 cycles after m_psel rises for writes, 29 for reads.
  int fcnt;
  always @(posedge s_pclk) begin
    if (s_preset) begin
      fcnt     <= 0;
      m_pready <= 1'b0;
      m_prdata <= '0;
    end else if (m_pready) begin
      m_pready <= 1'b0;
      fcnt     <= 0;
    end else if (m_psel) begin
      fcnt <= fcnt + 1;
      if (fcnt == (m_pwrite ? 1 : 28)) begin
        m_pready <= 1'b1;
        m_prdata <= m_pwrite ? 32'h0 : flash_fn(m_paddr);
      end
    end
  end

  // Count flash transactions and watch request stability while m_psel is high.
  int          txn_cnt = 0;
  int          stab_err = 0;
  logic        prev_psel = 1'b0;
  logic [31:0] rise_addr = '0;
  logic        rise_wr = 1'b0;
  always @(negedge s_pclk) begin
    if (m_psel === 1'b1 && prev_psel !== 1'b1) begin
      txn_cnt++;
      rise_addr = m_paddr;
      rise_wr   = m_pwrite;
    end else if (m_psel === 1'b1 && (m_paddr !== rise_addr || m_pwrite !== rise_wr)) begin
      stab_err++;
    end
    prev_psel = m_psel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request from the IDLE negedge; returns at the next IDLE negedge.
  task automatic do_req(input int idx, input bit wr, input logic [31:0] addr,
                        input bit flush_on_done, output logic [31:0] data,
                        output int lat, output bit gap_ok);
    lat  = -1;
    data = '0;
    r_psel[idx]           = 1'b1;
    r_pwrite[idx]         = wr;
    r_paddr[idx*32 +: 32] = addr;
    for (int c = 1; c <= 60; c++) begin
      @(negedge s_pclk);
      if (r_pready[idx] === 1'b1) begin
        lat  = c;
        data = r_prdata;
        if (flush_on_done) flush = 1'b1;
        break;
      end
    end
    r_psel[idx] = 1'b0;
    @(negedge s_pclk);
    flush  = 1'b0;
    gap_ok = (m_psel === 1'b0) && (r_pready === '0);
    @(negedge s_pclk);
  endtask

  task automatic test_reset();
    s_preset = 1'b1;
    r_psel   = '0;
    r_pwrite = '0;
    r_paddr  = '0;
    flush    = 1'b0;
    repeat (3) @(negedge s_pclk);
    checks++; if (m_psel !== 1'b0) begin errors++; $display("FAIL reset_m_psel got=%b exp=0", m_psel); end
    checks++; if (m_pwrite !== 1'b0) begin errors++; $display("FAIL reset_m_pwrite got=%b exp=0", m_pwrite); end
    checks++; if (m_paddr !== 32'h0) begin errors++; $display("FAIL reset_m_paddr got=%h exp=0", m_paddr); end
    checks++; if (r_pready !== 2'b00) begin errors++; $display("FAIL reset_r_pready got=%b exp=00", r_pready); end
    checks++; if (r_prdata !== 32'h0) begin errors++; $display("FAIL reset_r_prdata got=%h exp=0", r_prdata); end
    s_preset = 1'b0;
    @(negedge s_pclk);
  endtask

  task automatic test_single_read();
    logic [31:0] d; int lat; bit g; int t0, s0;
    t0 = txn_cnt; s0 = stab_err;
    do_req(0, 1'b0, 32'h0012_3456, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL single_lat got=%0d exp=30", lat); end
    checks++; if (d !== 32'hCAFE_BABE) begin errors++; $display("FAIL single_data got=%h exp=cafebabe", d); end
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL single_gap got=%b exp=1", g); end
    checks++; if (txn_cnt !== t0 + 1) begin errors++; $display("FAIL single_txn got=%0d exp=%0d", txn_cnt, t0 + 1); end
    checks++; if (rise_addr !== 32'h0012_3456) begin errors++; $display("FAIL single_m_paddr got=%h exp=00123456", rise_addr); end
    checks++; if (stab_err !== s0) begin errors++; $display("FAIL single_stable got=%0d exp=%0d", stab_err, s0); end
  endtask

  task automatic test_hit();
    logic [31:0] d; int lat; bit g; int t0;
    t0 = txn_cnt;
    do_req(1, 1'b0, 32'h0012_3456, 1'b0, d, lat, g);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hit_lat got=%0d exp=1", lat); end
    checks++; if (d !== 32'hCAFE_BABE) begin errors++; $display("FAIL hit_data got=%h exp=cafebabe", d); end
    checks++; if (txn_cnt !== t0) begin errors++; $display("FAIL hit_no_flash got=%0d exp=%0d", txn_cnt, t0); end
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL hit_gap got=%b exp=1", g); end
    flush = 1'b1;
    @(negedge s_pclk);
    flush = 1'b0;
    do_req(1, 1'b0, 32'h0012_3456, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL flush_miss_lat got=%0d exp=30", lat); end
    checks++; if (d !== 32'hCAFE_BABE) begin errors++; $display("FAIL flush_miss_data got=%h exp=cafebabe", d); end
    checks++; if (txn_cnt !== t0 + 1) begin errors++; $display("FAIL flush_miss_txn got=%0d exp=%0d", txn_cnt, t0 + 1); end
  endtask

  task automatic test_round_robin();
    int order[4];
    int n;
    logic [N-1:0] reraise;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    s_preset = 1'b1;
    @(negedge s_pclk);
    s_preset = 1'b0;
    n = 0;
    reraise = '0;
    r_pwrite = '0;
    r_paddr[0 +: 32]  = 32'h0000_0100;
    r_paddr[32 +: 32] = 32'h0000_0200;
    r_psel = 2'b11;
    for (int c = 0; c < 400 && n < 4; c++) begin
      @(negedge s_pclk);
      r_psel  = r_psel | reraise;
      reraise = '0;
      if (r_pready !== 2'b00) begin
        order[n] = (r_pready === 2'b10) ? 1 : 0;
        checks++;
        if (r_prdata !== flash_fn(r_paddr[order[n]*32 +: 32])) begin
          errors++;
          $display("FAIL rr_data%0d got=%h exp=%h", n, r_prdata, flash_fn(r_paddr[order[n]*32 +: 32]));
        end
        r_psel[order[n]]  = 1'b0;
        reraise[order[n]] = 1'b1;
        n++;
      end
    end
    r_psel = '0;
    repeat (3) @(negedge s_pclk);
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        checks++;
        if (order[k] !== exp_order[k]) begin
          errors++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_write_invalidate();
    logic [31:0] d; int lat; bit g;
    do_req(0, 1'b0, 32'h0000_0040, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL wi_fill_lat got=%0d exp=30", lat); end
    do_req(0, 1'b0, 32'h0000_0040, 1'b0, d, lat, g);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wi_hit_lat got=%0d exp=1", lat); end
    checks++; if (d !== 32'hA500_0040) begin errors++; $display("FAIL wi_hit_data got=%h exp=a5000040", d); end
    do_req(0, 1'b1, 32'h7F00_0040, 1'b0, d, lat, g);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat got=%0d exp=3", lat); end
    checks++; if (rise_addr !== 32'h7F00_0040) begin errors++; $display("FAIL wr_m_paddr got=%h exp=7f000040", rise_addr); end
    checks++; if (rise_wr !== 1'b1) begin errors++; $display("FAIL wr_m_pwrite got=%b exp=1", rise_wr); end
    do_req(0, 1'b0, 32'h0000_0040, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL wi_miss_lat got=%0d exp=30", lat); end
    checks++; if (d !== 32'hA500_0040) begin errors++; $display("FAIL wi_miss_data got=%h exp=a5000040", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d; int lat; bit g;
    // Buffer currently holds 0x40; a read of 0x777 goes to flash.
    r_psel[0]        = 1'b1;
    r_pwrite[0]      = 1'b0;
    r_paddr[0 +: 32] = 32'h0000_0777;
    repeat (19) @(negedge s_pclk);
    checks++; if (m_psel !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", m_psel); end
    s_preset  = 1'b1;
    r_psel[0] = 1'b0;
    @(negedge s_pclk);
    checks++; if (m_psel !== 1'b0) begin errors++; $display("FAIL mid_rst_m_psel got=%b exp=0", m_psel); end
    checks++; if (r_pready !== 2'b00) begin errors++; $display("FAIL mid_rst_r_pready got=%b exp=00", r_pready); end
    s_preset = 1'b0;
    @(negedge s_pclk);
    do_req(0, 1'b0, 32'h0000_0040, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL mid_rst_bufclr_lat got=%0d exp=30", lat); end
    do_req(0, 1'b0, 32'h0000_0777, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL mid_rst_after_lat got=%0d exp=30", lat); end
    checks++; if (d !== 32'hA500_0777) begin errors++; $display("FAIL mid_rst_after_data got=%h exp=a5000777", d); end
  endtask

  task automatic test_flush_collision();
    logic [31:0] d; int lat; bit g;
    do_req(1, 1'b0, 32'h0000_0ABC, 1'b1, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL coll_lat got=%0d exp=30", lat); end
    checks++; if (d !== 32'hA500_0ABC) begin errors++; $display("FAIL coll_data got=%h exp=a5000abc", d); end
    do_req(1, 1'b0, 32'h0000_0ABC, 1'b0, d, lat, g);
    checks++; if (lat !== 30) begin errors++; $display("FAIL coll_miss_lat got=%0d exp=30", lat); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_hit();
    test_round_robin();
    test_write_invalidate();
    test_reset_mid_read();
    test_flush_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
